// File: rtl/sar_conv_responder.sv
// Successive-approximation converter responding to a four-phase SOC/EOC handshake.
// Drives trial codes to an external DAC and builds the result from comparator samples.
module sar_conv_responder #(
    parameter int N      = 8,
    parameter int SETTLE = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soc,
    output logic         eoc,
    output logic [N-1:0] x,
    output logic [N-1:0] dac,
    input  logic         cmp
);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] MSB_BIT = N'(1) << (N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        CONV
    } state_t;

    state_t        state_reg;
    logic          eoc_reg;
    logic [N-1:0]  x_reg;
    logic [N-1:0]  dac_reg;
    logic [N-1:0]  result_reg;
    logic [IW-1:0] idx_reg;
    logic [CW-1:0] cnt_reg;

    // decided_next: result with the current bit replaced by cmp; trial_next adds the next trial bit
    logic [N-1:0]  decided_next;
    logic [N-1:0]  trial_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign decided_next[gi] = (idx_reg == IW'(gi)) ? cmp : result_reg[gi];
            if (gi < N - 1) begin : g_low
                assign trial_next[gi] = decided_next[gi] | (idx_reg == IW'(gi + 1));
            end else begin : g_top
                assign trial_next[gi] = decided_next[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            eoc_reg    <= 1'b1;
            x_reg      <= '0;
            dac_reg    <= '0;
            result_reg <= '0;
            idx_reg    <= IW'(N - 1);
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (soc) begin
                        eoc_reg   <= 1'b0;
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    if (!soc) begin
                        dac_reg    <= MSB_BIT;
                        result_reg <= '0;
                        idx_reg    <= IW'(N - 1);
                        cnt_reg    <= CW'(SETTLE);
                        state_reg  <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        result_reg <= decided_next;
                        if (idx_reg != '0) begin
                            dac_reg <= trial_next;
                            idx_reg <= idx_reg - IW'(1);
                            cnt_reg <= CW'(SETTLE);
                        end else begin
                            // x and eoc move together so x is valid in the first eoc=1 cycle
                            x_reg     <= decided_next;
                            eoc_reg   <= 1'b1;
                            dac_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign eoc = eoc_reg;
    assign x   = x_reg;
    assign dac = dac_reg;
endmodule

// File: tb/tb_sar_conv_responder.sv
// Three responders share one soc line (two with SETTLE=1, one with SETTLE=0),
// each with its own comparator model cmp = (dac <= A).
`timescale 1ns/1ps
module tb_sar_conv_responder;
    localparam int N = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soc   = 1'b0;
    logic [7:0] a       [3];
    logic       eoc_w   [3];
    logic [7:0] x_w     [3];
    logic [7:0] dac_w   [3];
    logic       cmp_w   [3];
    logic [7:0] exp_x   [3];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign cmp_w[0] = (dac_w[0] <= a[0]);
    assign cmp_w[1] = (dac_w[1] <= a[1]);
    assign cmp_w[2] = (dac_w[2] <= a[2]);

    sar_conv_responder #(.N(8), .SETTLE(1)) u0 (
        .clock(clock), .reset(reset), .soc(soc), .eoc(eoc_w[0]),
        .x(x_w[0]), .dac(dac_w[0]), .cmp(cmp_w[0]));
    sar_conv_responder #(.N(8), .SETTLE(1)) u1 (
        .clock(clock), .reset(reset), .soc(soc), .eoc(eoc_w[1]),
        .x(x_w[1]), .dac(dac_w[1]), .cmp(cmp_w[1]));
    sar_conv_responder #(.N(8), .SETTLE(0)) u2 (
        .clock(clock), .reset(reset), .soc(soc), .eoc(eoc_w[2]),
        .x(x_w[2]), .dac(dac_w[2]), .cmp(cmp_w[2]));

    function automatic int settle_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    // Binary search: the code presented on the DAC while bit k (from the MSB) is being tried
    function automatic logic [7:0] trial_code(input logic [7:0] av, input int k);
        logic [7:0] res;
        logic [7:0] t;
        res = '0;
        for (int j = 0; j < k; j++) begin
            t = res | (8'd128 >> j);
            if (t <= av) res = t;
        end
        return res | (8'd128 >> k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run_conv(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                            input int hold, input bit early, input bit pre_acked);
        int s;
        int len;
        a[0] = a0; a[1] = a1; a[2] = a2;
        if (!pre_acked) begin
            soc = 1'b1;
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) check($sformatf("ack_eoc%0d", i), 32'(eoc_w[i]), 0);
        end
        for (int h = 1; h < hold; h++) begin
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("hold_eoc%0d", i), 32'(eoc_w[i]), 0);
                check($sformatf("hold_dac%0d", i), 32'(dac_w[i]), 0);
                check($sformatf("hold_x%0d", i), 32'(x_w[i]), 32'(exp_x[i]));
            end
        end
        soc = 1'b0;
        for (int m = 0; m <= 16; m++) begin
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) begin
                s   = settle_of(i);
                len = N * (s + 1);
                if (m < len) begin
                    check($sformatf("conv_eoc%0d_m%0d", i, m), 32'(eoc_w[i]), 0);
                    check($sformatf("conv_dac%0d_m%0d", i, m), 32'(dac_w[i]),
                          32'(trial_code(a[i], m / (s + 1))));
                    check($sformatf("conv_x%0d_m%0d", i, m), 32'(x_w[i]), 32'(exp_x[i]));
                end else if (m == len) begin
                    check($sformatf("done_eoc%0d", i), 32'(eoc_w[i]), 1);
                    check($sformatf("done_x%0d", i), 32'(x_w[i]), 32'(a[i]));
                    check($sformatf("done_dac%0d", i), 32'(dac_w[i]), 0);
                end else begin
                    check($sformatf("idle_x%0d_m%0d", i, m), 32'(x_w[i]), 32'(a[i]));
                    check($sformatf("idle_eoc%0d_m%0d", i, m), 32'(eoc_w[i]),
                          (early && m == 16) ? 0 : 1);
                end
            end
            if (early && m == 15) soc = 1'b1;
        end
        for (int i = 0; i < 3; i++) exp_x[i] = a[i];
        if (early) begin
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) check($sformatf("b2b_ack%0d", i), 32'(eoc_w[i]), 0);
        end
    endtask

    task automatic abort_conv(input logic [7:0] av);
        for (int i = 0; i < 3; i++) a[i] = av;
        soc = 1'b1;
        @(posedge clock); #1;
        soc = 1'b0;
        repeat (6) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_eoc%0d", i), 32'(eoc_w[i]), 1);
            check($sformatf("abort_x%0d", i), 32'(x_w[i]), 0);
            check($sformatf("abort_dac%0d", i), 32'(dac_w[i]), 0);
            exp_x[i] = '0;
        end
        #1 reset = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) check($sformatf("post_abort_eoc%0d", i), 32'(eoc_w[i]), 1);
    endtask

    initial begin
        bit prev_early;
        bit early;
        int hold;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            exp_x[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_eoc%0d", i), 32'(eoc_w[i]), 1);
            check($sformatf("rst_x%0d", i), 32'(x_w[i]), 0);
            check($sformatf("rst_dac%0d", i), 32'(dac_w[i]), 0);
        end
        reset = 1'b0;
        @(posedge clock); #1;

        run_conv(8'd100, 8'd51, 8'd100, 2, 1'b0, 1'b0);
        run_conv(8'd0, 8'd255, 8'd0, 2, 1'b0, 1'b0);
        run_conv(8'd255, 8'd0, 8'd255, 11, 1'b0, 1'b0);
        run_conv(8'd100, 8'd51, 8'd7, 3, 1'b1, 1'b0);
        run_conv(8'd100, 8'd51, 8'd100, 2, 1'b0, 1'b1);
        abort_conv(8'd200);
        run_conv(8'd200, 8'd200, 8'd200, 2, 1'b0, 1'b0);

        prev_early = 1'b0;
        for (int it = 0; it < 10; it++) begin
            hold  = int'($urandom_range(1, 12));
            early = (it < 9) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_conv(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), hold, early, prev_early);
            prev_early = early;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sar_conv_responder.md
Name: sar_conv_responder

Overview:
- Converter-side responder for the SOC/EOC start-of-conversion handshake. The existing pulse-generator controller drives one soc line to two of these blocks and reads their x outputs.
- Implements an N-bit successive-approximation conversion: drives a DAC code, samples an external comparator, and presents the result on x together with EOC.
- One instance per analog channel. The controller's soc fans out to both instances, and their eoc/x outputs feed its eoc1/eoc2 and x1/x2 inputs.

Parameters:
- N, 8, conversion width in bits (x and dac width).
- SETTLE, 1, extra clock cycles between a DAC update and the comparator sample (0 = sample on the next edge).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- soc  in  1  start of conversion from the controller.
- eoc  out  1  end of conversion; 1 = idle / result valid.
- x  out  N  conversion result; valid and stable whenever eoc=1.
- dac  out  N  trial code to the external DAC.
- cmp  in  1  comparator result: 1 when analog input >= DAC output, sampled synchronously.

Behaviour:
- Reset (asynchronous, overrides everything, aborts any conversion): eoc=1, x=0, dac=0, result register=0, bit index=N-1, settle counter=0, state=IDLE.
- All outputs are registered. There is no combinational path from soc or cmp to any output.
- Handshake is four-phase:
  - Idle: eoc=1, soc=0.
  - Controller raises soc; responder drops eoc.
  - Controller drops soc; responder converts.
  - Responder raises eoc with x valid.
- IDLE: eoc=1, x holds the previous result. When soc=1 is sampled, eoc<=0 and the state goes to ACK.
- ACK: eoc=0. Waits while soc=1; no conversion starts while soc is held high, for any duration. When soc=0 is sampled (edge T0):
  - dac<=1<<(N-1), result<=0, bit index<=N-1, counter<=SETTLE.
  - State goes to CONV.
- CONV, every edge:
  - If counter≠0: counter decrements, dac holds.
  - If counter=0 (decide edge): result[i]<=cmp, where i is the bit index.
    - If i>0: dac<=(result with bit i = cmp) | 1<<(i-1), i<=i-1, counter<=SETTLE.
    - If i=0: x<=final result, eoc<=1, dac<=0, state goes to IDLE. x and eoc update on the same edge, so x is valid in the first cycle eoc=1.
- Timing:
  - Bit k (counted from the MSB, k=0..N-1) is decided at edge T0+(k+1)(SETTLE+1).
  - eoc rises at edge T0+N(SETTLE+1): 16 cycles for the defaults.
- soc during CONV is ignored. soc=1 when returning to IDLE is sampled in IDLE on the following edge and starts a new handshake, so eoc is high for at least one cycle.
- x changes only on the edge where eoc rises. It never changes while eoc=0 or while idle.
- cmp is don't-care outside decide edges.
- Width rules: dac and result are N bits. No arithmetic beyond the counter (width ceil(log2(SETTLE+1)), minimum 1) and the bit index (ceil(log2 N) bits).

Test Plan:
- Bench model: cmp = (dac <= A), combinational, from an analog value A.
- A=100, N=8, SETTLE=1. Pulse soc high for 2 cycles. Required:
  - eoc falls one edge after soc is sampled.
  - dac trials are 128, 64, 96, 112, 104, 100, 102, 101.
  - eoc rises 16 cycles after soc=0 is sampled, with x=100 in the same cycle.
- A=0 → x=0 (trials 128, 64, ..., 1). A=255 → x=255. With SETTLE=0, eoc rises exactly 8 cycles after T0.
- Hold soc=1 for 10 cycles after eoc falls. Required: eoc stays 0, dac stays 0, no conversion. Conversion starts only after soc=0, and x is unchanged until completion.
- Assert reset 5 cycles into a conversion with A=200 (previous x=100). Required: immediately eoc=1, x=0, dac=0. A new handshake converts to x=200.
- Two instances (A=100, A=51) driven by the existing controller. Required:
  - Both eoc fall, then both rise with x1=100 and x2=51.
  - Controller out is high for 75 cycles.
  - Back-to-back conversions repeat cleanly, with eoc high at least one cycle between them.
